// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD block controller.
package sad_pkg;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DRAIN = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6
  } sad_state_e;

  // Elements per block and width of the i_inc watchdog counter.
  localparam int SAD_N_ELEM = 256;
  localparam int SAD_WD_W   = 9;

  // Legal sample-memory read latencies: 0 = async read, 1 = registered read.
  localparam int SAD_RD_LAT_MIN = 0;
  localparam int SAD_RD_LAT_MAX = 1;

  // Moore outputs held in one register next to the state.
  typedef struct packed {
    logic busy;
    logic done;
    logic i_clr;
    logic sum_clr;
    logic sadreg_clr;
    logic accum;
    logic store;
  } sad_out_t;

  // Moore output decode for a given state.
  function automatic sad_out_t sad_decode(input sad_state_e st);
    sad_out_t o;
    o = '0;
    case (st)
      ST_INIT: begin
        o.i_clr      = 1'b1;
        o.sum_clr    = 1'b1;
        o.sadreg_clr = 1'b1;
      end
      ST_IDLE: o = '0;
      ST_CLEAR: begin
        o.busy    = 1'b1;
        o.i_clr   = 1'b1;
        o.sum_clr = 1'b1;
      end
      ST_ACCUM: begin
        o.busy  = 1'b1;
        o.accum = 1'b1;
      end
      ST_DRAIN: o.busy = 1'b1;
      ST_STORE: begin
        o.busy  = 1'b1;
        o.store = 1'b1;
      end
      ST_DONE: begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sad_ctrl_if.sv
// Host-side go/abort/busy/done/err handshake of the SAD controller.
interface sad_ctrl_if;
  logic go;
  logic abort;
  logic busy;
  logic done;
  logic err;

  // Host drives requests and observes status.
  modport master (output go, output abort, input busy, input done, input err);
  // Controller consumes requests and reports status.
  modport slave  (input go, input abort, output busy, output done, output err);
endinterface

// File: rtl/sad_ld_pipe.sv
// RD_LAT-deep valid shift register that turns address issues into sum loads.
// With RD_LAT=0 the issue bit is passed straight through.
module sad_ld_pipe #(
  parameter int RD_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic vld_i,
  output logic vld_o
);

  localparam int DEPTH = (RD_LAT > 0) ? RD_LAT : 1;

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift in the new issue bit unless the pipe is being flushed.
  always_comb begin
    pipe_d = '0;
    if (flush_i) begin
      pipe_d = '0;
    end else begin
      pipe_d = (pipe_q << 1) | DEPTH'(vld_i);
    end
  end

  // Valid-bit storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_o = (RD_LAT == 0) ? (vld_i & ~flush_i) : pipe_q[DEPTH-1];

endmodule

// File: rtl/sad_ctrl.sv
// Controller that sequences the SAD datapath over one block of N_ELEM
// elements, with host handshake, abort and an i_inc overrun watchdog.
module sad_ctrl
  import sad_pkg::*;
#(
  parameter int RD_LAT = 0,
  parameter int N_ELEM = SAD_N_ELEM
) (
  input  logic       clk,
  input  logic       rst,
  sad_ctrl_if.slave  host,
  input  logic       i_lt_256,
  output logic       i_clr,
  output logic       i_inc,
  output logic       sum_clr,
  output logic       sum_ld,
  output logic       sadreg_clr,
  output logic       sadreg_ld
);

  sad_state_e          state_q;
  sad_out_t            out_q;
  logic                err_q;
  logic [SAD_WD_W-1:0] wd_cnt_q;

  logic wd_hit_s;
  logic wd_trip_s;
  logic abort_cut_s;
  logic flush_s;

  // Watchdog limit reached; a trip only counts while the datapath still
  // reports addresses left, so a normal last cycle never trips it.
  assign wd_hit_s    = (wd_cnt_q == SAD_WD_W'(N_ELEM));
  assign wd_trip_s   = out_q.accum & wd_hit_s & i_lt_256;
  assign abort_cut_s = host.abort & ((state_q == ST_CLEAR) | (state_q == ST_ACCUM) |
                                     (state_q == ST_DRAIN) | (state_q == ST_STORE));
  assign flush_s     = out_q.i_clr | abort_cut_s | wd_trip_s;

  // Sequencing FSM: next state and its Moore outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      out_q    <= sad_decode(ST_INIT);
      err_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      if (i_inc) begin
        wd_cnt_q <= wd_cnt_q + SAD_WD_W'(1);
      end
      case (state_q)
        ST_INIT: begin
          state_q <= ST_IDLE;
          out_q   <= sad_decode(ST_IDLE);
        end
        ST_IDLE: begin
          // abort beats a simultaneous go
          if (host.go && !host.abort) begin
            state_q <= ST_CLEAR;
            out_q   <= sad_decode(ST_CLEAR);
            err_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wd_cnt_q <= '0;
          if (host.abort) begin
            state_q <= ST_IDLE;
            out_q   <= sad_decode(ST_IDLE);
          end else begin
            state_q <= ST_ACCUM;
            out_q   <= sad_decode(ST_ACCUM);
          end
        end
        ST_ACCUM: begin
          if (host.abort) begin
            state_q <= ST_IDLE;
            out_q   <= sad_decode(ST_IDLE);
          end else if (wd_trip_s) begin
            state_q <= ST_IDLE;
            out_q   <= sad_decode(ST_IDLE);
            err_q   <= 1'b1;
          end else if (!i_lt_256) begin
            // last address is being issued this cycle
            if (RD_LAT >= SAD_RD_LAT_MAX) begin
              state_q <= ST_DRAIN;
              out_q   <= sad_decode(ST_DRAIN);
            end else begin
              state_q <= ST_STORE;
              out_q   <= sad_decode(ST_STORE);
            end
          end
        end
        ST_DRAIN: begin
          if (host.abort) begin
            state_q <= ST_IDLE;
            out_q   <= sad_decode(ST_IDLE);
          end else begin
            state_q <= ST_STORE;
            out_q   <= sad_decode(ST_STORE);
          end
        end
        ST_STORE: begin
          if (host.abort) begin
            state_q <= ST_IDLE;
            out_q   <= sad_decode(ST_IDLE);
          end else begin
            state_q <= ST_DONE;
            out_q   <= sad_decode(ST_DONE);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          out_q   <= sad_decode(ST_IDLE);
        end
        default: begin
          state_q <= ST_INIT;
          out_q   <= sad_decode(ST_INIT);
        end
      endcase
    end
  end

  sad_ld_pipe #(.RD_LAT(RD_LAT)) u_ld_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_s),
    .vld_i   (out_q.accum),
    .vld_o   (sum_ld)
  );

  // i_inc stops on the final address and once the watchdog limit is hit;
  // an abort in STORE suppresses the result load.
  assign i_clr      = out_q.i_clr;
  assign i_inc      = out_q.accum & i_lt_256 & ~wd_hit_s;
  assign sum_clr    = out_q.sum_clr;
  assign sadreg_clr = out_q.sadreg_clr;
  assign sadreg_ld  = out_q.store & ~host.abort;
  assign host.busy  = out_q.busy;
  assign host.done  = out_q.done;
  assign host.err   = err_q;

endmodule

// File: tb/tb_sad_ctrl.sv
// Bench for sad_ctrl: one DUT per read latency (0 and 1), each with a
// behavioural SAD datapath and memory model, checked against expected
// sums computed by plain arithmetic and timings derived from the run rules.
module tb_sad_ctrl;

  logic clk = 1'b0;
  logic rst, go_s, abort_s, stuck_s, mon_clr;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  logic [1:0] i_clr_a, i_inc_a, sum_clr_a, sum_ld_a, sadreg_clr_a, sadreg_ld_a;
  logic [1:0] busy_a, done_a, err_a, lt_a;

  logic [7:0]  addr_r [2];
  logic [7:0]  rdq_a_r [2];
  logic [7:0]  rdq_b_r [2];
  logic [19:0] sum_r [2];
  logic [19:0] sad_r [2];

  int n_inc [2], n_ld [2], n_sadld [2], n_done [2], n_busy [2];
  int f_inc [2], l_inc [2], f_ld [2], l_ld [2], f_done [2], l_done [2];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      sad_ctrl_if u_if ();
      assign u_if.go    = go_s;
      assign u_if.abort = abort_s;
      assign busy_a[g]  = u_if.busy;
      assign done_a[g]  = u_if.done;
      assign err_a[g]   = u_if.err;

      sad_ctrl #(.RD_LAT(g), .N_ELEM(256)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .host       (u_if),
        .i_lt_256   (lt_a[g]),
        .i_clr      (i_clr_a[g]),
        .i_inc      (i_inc_a[g]),
        .sum_clr    (sum_clr_a[g]),
        .sum_ld     (sum_ld_a[g]),
        .sadreg_clr (sadreg_clr_a[g]),
        .sadreg_ld  (sadreg_ld_a[g])
      );
    end
  endgenerate

  function automatic logic [19:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? 20'(a - b) : 20'(b - a);
  endfunction

  // Cycle counter: value equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath flag: last address presented, unless forced stuck at 1.
  always_comb begin
    lt_a = 2'b00;
    for (int l = 0; l < 2; l++) lt_a[l] = stuck_s | (addr_r[l] != 8'd255);
  end

  // Datapath model: address counter, async (lane 0) or registered (lane 1) reads, sum and sad registers.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (i_clr_a[l]) addr_r[l] <= 8'd0;
      else if (i_inc_a[l]) addr_r[l] <= addr_r[l] + 8'd1;
      rdq_a_r[l] <= mem_a[addr_r[l]];
      rdq_b_r[l] <= mem_b[addr_r[l]];
      if (sum_clr_a[l]) sum_r[l] <= 20'd0;
      else if (sum_ld_a[l])
        sum_r[l] <= sum_r[l] + ((l == 0) ? absd(mem_a[addr_r[l]], mem_b[addr_r[l]])
                                         : absd(rdq_a_r[l], rdq_b_r[l]));
      if (sadreg_clr_a[l]) sad_r[l] <= 20'd0;
      else if (sadreg_ld_a[l]) sad_r[l] <= sum_r[l];
    end
  end

  // Pulse monitor sampled mid-cycle: counts and first/last cycle of each event.
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (mon_clr) begin
        n_inc[l] <= 0; n_ld[l] <= 0; n_sadld[l] <= 0; n_done[l] <= 0; n_busy[l] <= 0;
        f_inc[l] <= -1; l_inc[l] <= -1; f_ld[l] <= -1; l_ld[l] <= -1;
        f_done[l] <= -1; l_done[l] <= -1;
      end else begin
        if (i_inc_a[l]) begin
          n_inc[l] <= n_inc[l] + 1;
          if (f_inc[l] < 0) f_inc[l] <= cyc;
          l_inc[l] <= cyc;
        end
        if (sum_ld_a[l]) begin
          n_ld[l] <= n_ld[l] + 1;
          if (f_ld[l] < 0) f_ld[l] <= cyc;
          l_ld[l] <= cyc;
        end
        if (done_a[l]) begin
          n_done[l] <= n_done[l] + 1;
          if (f_done[l] < 0) f_done[l] <= cyc;
          l_done[l] <= cyc;
        end
        if (sadreg_ld_a[l]) n_sadld[l] <= n_sadld[l] + 1;
        if (busy_a[l]) n_busy[l] <= n_busy[l] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present go for exactly one sampling edge; e = cycle index of that edge.
  task automatic start_run(output int e);
    mon_clr = 1'b1;
    go_s    = 1'b1;
    tick(1);
    e       = cyc;
    go_s    = 1'b0;
    mon_clr = 1'b0;
  endtask

  function automatic int ref_sad();
    int s;
    s = 0;
    for (int k = 0; k < 256; k++)
      s += (mem_a[k] > mem_b[k]) ? int'(mem_a[k]) - int'(mem_b[k]) : int'(mem_b[k]) - int'(mem_a[k]);
    return s;
  endfunction

  // Relative to the go edge: CLEAR at 0, ACCUM at 1..256, extra DRAIN for
  // latency 1, then STORE and DONE.
  task automatic check_run(input string nm, input int e, input int exp_sad);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("%s_L%0d_done_n", nm, l), n_done[l], 1);
      check_eq($sformatf("%s_L%0d_done_at", nm, l), f_done[l] - e, 258 + l);
      check_eq($sformatf("%s_L%0d_inc_n", nm, l), n_inc[l], 255);
      check_eq($sformatf("%s_L%0d_ld_n", nm, l), n_ld[l], 256);
      check_eq($sformatf("%s_L%0d_inc_first", nm, l), f_inc[l] - e, 1);
      check_eq($sformatf("%s_L%0d_inc_last", nm, l), l_inc[l] - e, 255);
      check_eq($sformatf("%s_L%0d_ld_first", nm, l), f_ld[l] - e, 1 + l);
      check_eq($sformatf("%s_L%0d_ld_last", nm, l), l_ld[l] - e, 256 + l);
      check_eq($sformatf("%s_L%0d_sadld_n", nm, l), n_sadld[l], 1);
      check_eq($sformatf("%s_L%0d_busy_n", nm, l), n_busy[l], 259 + l);
      check_eq($sformatf("%s_L%0d_sad", nm, l), int'(sad_r[l]), exp_sad);
      check_eq($sformatf("%s_L%0d_busy_end", nm, l), int'(busy_a[l]), 0);
      check_eq($sformatf("%s_L%0d_err", nm, l), int'(err_a[l]), 0);
    end
  endtask

  initial begin
    int e;
    int exp_sad;
    rst = 1'b1; go_s = 1'b0; abort_s = 1'b0; stuck_s = 1'b0; mon_clr = 1'b1;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'd0;
      mem_b[k] = 8'd0;
    end
    tick(3);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("rst_L%0d_clr", l), int'({i_clr_a[l], sum_clr_a[l], sadreg_clr_a[l]}), 7);
      check_eq($sformatf("rst_L%0d_others", l),
               int'({i_inc_a[l], sum_ld_a[l], sadreg_ld_a[l], done_a[l], err_a[l]}), 0);
    end
    rst = 1'b0;
    tick(1);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("idle_L%0d_outs", l),
               int'({busy_a[l], i_clr_a[l], sum_clr_a[l], sadreg_clr_a[l], i_inc_a[l]}), 0);
      check_eq($sformatf("idle_L%0d_sad", l), int'(sad_r[l]), 0);
    end

    // A[k]=k, B[k]=255-k
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'(k);
      mem_b[k] = 8'(255 - k);
    end
    check_eq("ramp_ref", ref_sad(), 32768);
    start_run(e);
    tick(265);
    check_run("ramp", e, ref_sad());

    // A=5, B=3
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'd5;
      mem_b[k] = 8'd3;
    end
    start_run(e);
    tick(265);
    check_run("const", e, 512);

    // A=7, B=0 with abort during relative cycle 100
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'd7;
      mem_b[k] = 8'd0;
    end
    start_run(e);
    tick(99);
    abort_s = 1'b1;
    tick(1);
    abort_s = 1'b0;
    for (int l = 0; l < 2; l++) check_eq($sformatf("abort_L%0d_busy_next", l), int'(busy_a[l]), 0);
    tick(280);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("abort_L%0d_done_n", l), n_done[l], 0);
      check_eq($sformatf("abort_L%0d_sadld_n", l), n_sadld[l], 0);
      check_eq($sformatf("abort_L%0d_sad", l), int'(sad_r[l]), 512);
      check_eq($sformatf("abort_L%0d_busy", l), int'(busy_a[l]), 0);
    end

    // Watchdog: i_lt_256 stuck at 1
    stuck_s = 1'b1;
    start_run(e);
    tick(300);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("wd_L%0d_inc_n", l), n_inc[l], 256);
      check_eq($sformatf("wd_L%0d_sadld_n", l), n_sadld[l], 0);
      check_eq($sformatf("wd_L%0d_done_n", l), n_done[l], 0);
      check_eq($sformatf("wd_L%0d_err", l), int'(err_a[l]), 1);
      check_eq($sformatf("wd_L%0d_busy", l), int'(busy_a[l]), 0);
      check_eq($sformatf("wd_L%0d_sad", l), int'(sad_r[l]), 512);
    end
    stuck_s = 1'b0;

    // Random data; the accepted go also clears err
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'($urandom_range(0, 255));
      mem_b[k] = 8'($urandom_range(0, 255));
    end
    exp_sad = ref_sad();
    start_run(e);
    for (int l = 0; l < 2; l++) check_eq($sformatf("errclr_L%0d", l), int'(err_a[l]), 0);
    tick(265);
    check_run("rand", e, exp_sad);

    // Back-to-back: go held high across DONE
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 8'($urandom_range(0, 255));
      mem_b[k] = 8'($urandom_range(0, 255));
    end
    exp_sad = ref_sad();
    mon_clr = 1'b1;
    go_s    = 1'b1;
    tick(1);
    e       = cyc;
    mon_clr = 1'b0;
    tick(262);
    go_s = 1'b0;
    tick(300);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("b2b_L%0d_done_n", l), n_done[l], 2);
      check_eq($sformatf("b2b_L%0d_done1_at", l), f_done[l] - e, 258 + l);
      check_eq($sformatf("b2b_L%0d_done_gap", l), l_done[l] - f_done[l], 260 + l);
      check_eq($sformatf("b2b_L%0d_sadld_n", l), n_sadld[l], 2);
      check_eq($sformatf("b2b_L%0d_sad", l), int'(sad_r[l]), exp_sad);
    end

    // Reset pulse mid-ACCUM
    start_run(e);
    tick(50);
    rst = 1'b1;
    tick(1);
    for (int l = 0; l < 2; l++)
      check_eq($sformatf("mrst_L%0d_init_clr", l), int'({i_clr_a[l], sadreg_clr_a[l], i_inc_a[l]}), 6);
    rst = 1'b0;
    tick(1);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("mrst_L%0d_sad", l), int'(sad_r[l]), 0);
      check_eq($sformatf("mrst_L%0d_busy", l), int'(busy_a[l]), 0);
      check_eq($sformatf("mrst_L%0d_err", l), int'(err_a[l]), 0);
    end
    tick(280);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("mrst_L%0d_done_n", l), n_done[l], 0);
      check_eq($sformatf("mrst_L%0d_sadld_n", l), n_sadld[l], 0);
    end

    // go and abort together in IDLE
    mon_clr = 1'b1;
    go_s    = 1'b1;
    abort_s = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    tick(3);
    go_s    = 1'b0;
    abort_s = 1'b0;
    tick(3);
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("goab_L%0d_busy_n", l), n_busy[l], 0);
      check_eq($sformatf("goab_L%0d_inc_n", l), n_inc[l], 0);
      check_eq($sformatf("goab_L%0d_sad", l), int'(sad_r[l]), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
